// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: shares one framebuffer write port between four pixel
// writers (round-robin) and a full-frame clear sequencer.
// Handshake: chK_valid is the requester's "write pending" flag and must hold
// x/y/data stable until chK_ready is seen high; a transfer completes on a
// clock edge where chK_valid && chK_ready. chK_ready is combinational from
// registered state plus the four valid bits and clear_start only.
module fb_write_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ch1_valid,
  input  logic [ADDR_W-1:0] ch1_x,
  input  logic [ADDR_W-1:0] ch1_y,
  input  logic [DATA_W-1:0] ch1_data,
  output logic              ch1_ready,
  input  logic              ch2_valid,
  input  logic [ADDR_W-1:0] ch2_x,
  input  logic [ADDR_W-1:0] ch2_y,
  input  logic [DATA_W-1:0] ch2_data,
  output logic              ch2_ready,
  input  logic              ch3_valid,
  input  logic [ADDR_W-1:0] ch3_x,
  input  logic [ADDR_W-1:0] ch3_y,
  input  logic [DATA_W-1:0] ch3_data,
  output logic              ch3_ready,
  input  logic              ch4_valid,
  input  logic [ADDR_W-1:0] ch4_x,
  input  logic [ADDR_W-1:0] ch4_y,
  input  logic [DATA_W-1:0] ch4_data,
  output logic              ch4_ready,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_x,
  output logic [ADDR_W-1:0] mem_y,
  output logic [DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]  drop_count,
  output logic              dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  localparam logic [ADDR_W:0]   LP_H     = (ADDR_W+1)'(H_RES);
  localparam logic [ADDR_W:0]   LP_V     = (ADDR_W+1)'(V_RES);
  localparam logic [ADDR_W-1:0] LP_X_END = ADDR_W'(H_RES - 1);
  localparam logic [ADDR_W-1:0] LP_Y_END = ADDR_W'(V_RES - 1);

  state_t                   r_state, w_next;
  logic [1:0]               r_last;   // index of last granted channel (0=ch1)
  logic [DATA_W-1:0]        r_color;
  logic [ADDR_W-1:0]        r_cx, r_cy;

  logic [3:0]               w_valid;
  logic [3:0][ADDR_W-1:0]   w_x, w_y;
  logic [3:0][DATA_W-1:0]   w_d;
  logic [3:0]               w_grant;
  logic [1:0]               w_gidx, w_idx;
  logic                     w_found, w_oor, w_clear_last;

  assign w_valid = {ch4_valid, ch3_valid, ch2_valid, ch1_valid};
  assign w_x     = {ch4_x, ch3_x, ch2_x, ch1_x};
  assign w_y     = {ch4_y, ch3_y, ch2_y, ch1_y};
  assign w_d     = {ch4_data, ch3_data, ch2_data, ch1_data};

  assign {ch4_ready, ch3_ready, ch2_ready, ch1_ready} = w_grant;

  assign w_clear_last = (r_cx == LP_X_END) && (r_cy == LP_Y_END);

  // Round-robin pick: first valid channel after r_last, only in IDLE without a clear request
  always_comb begin
    w_found = 1'b0;
    w_gidx  = r_last;
    w_idx   = r_last;
    w_grant = '0;
    if (r_state == S_IDLE && !clear_start) begin
      for (int i = 1; i < 5; i++) begin
        w_idx = r_last + 2'(i);
        if (!w_found && w_valid[w_idx]) begin
          w_found = 1'b1;
          w_gidx  = w_idx;
        end
      end
    end
    if (w_found) w_grant[w_gidx] = 1'b1;
  end

  // Winner's coordinates outside the frame: accepted but not written
  always_comb begin
    w_oor = ({1'b0, w_x[w_gidx]} >= LP_H) || ({1'b0, w_y[w_gidx]} >= LP_V);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: enter CLEAR on request, leave after the last raster pixel
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (clear_start)  w_next = S_CLEAR;
      S_CLEAR: if (w_clear_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    clear_busy = (r_state == S_CLEAR);
    dbg_state  = r_state;
  end

  // Write-port datapath, clear raster counters, arbitration pointer, drop counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_x      <= '0;
      mem_y      <= '0;
      mem_data   <= '0;
      drop_count <= '0;
      r_last     <= 2'd3;
      r_color    <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
    end else if (r_state == S_CLEAR) begin
      mem_we   <= 1'b1;
      mem_x    <= r_cx;
      mem_y    <= r_cy;
      mem_data <= r_color;
      if (r_cx == LP_X_END) begin
        r_cx <= '0;
        r_cy <= (r_cy == LP_Y_END) ? '0 : r_cy + ADDR_W'(1);
      end else begin
        r_cx <= r_cx + ADDR_W'(1);
      end
    end else begin
      mem_we <= 1'b0;
      if (clear_start) begin
        r_color <= clear_color;
        r_cx    <= '0;
        r_cy    <= '0;
      end else if (w_found) begin
        r_last <= w_gidx;
        if (w_oor) begin
          if (drop_count != {CNT_W{1'b1}}) drop_count <= drop_count + CNT_W'(1);
        end else begin
          mem_we   <= 1'b1;
          mem_x    <= w_x[w_gidx];
          mem_y    <= w_y[w_gidx];
          mem_data <= w_d[w_gidx];
        end
      end
    end
  end

endmodule
